// File: rtl/imem_loader.sv
// imem_loader: streams a program into an instruction word array,
// then serves zero-latency fetches by byte PC while run is high.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start_load,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  run,
    input  logic [31:0]           fetch_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  beat;
    logic                  at_end;
    logic                  clr;
    logic [ADDR_WIDTH-1:0] ridx;
    logic                  hit;
    logic                  unused_addr;

    // A restart request takes priority over a coincident beat.
    assign beat   = load_valid & load_ready & ~start_load;
    assign at_end = &wptr;
    assign clr    = start_load & (state != ERR);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; ERR is left only through RESET.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_load) state_nx = LOAD;
            end
            LOAD: begin
                if (start_load) begin
                    state_nx = LOAD;
                end else if (beat && load_last) begin
                    state_nx = RUN;
                end else if (beat && at_end) begin
                    state_nx = ERR;
                end
            end
            RUN: begin
                if (start_load) state_nx = LOAD;
            end
            ERR: begin
                state_nx = ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode from state only, never from load_valid.
    always_comb begin
        load_ready = (state == LOAD);
        run        = (state == RUN);
        error      = (state == ERR);
    end

    // Write pointer and loaded-word count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr       <= '0;
            word_count <= '0;
        end else if (clr) begin
            wptr       <= '0;
            word_count <= '0;
        end else if (beat) begin
            wptr       <= wptr + 1'b1;
            word_count <= word_count + 1'b1;
        end
    end

    // Program store; contents survive reset, reads are gated by count.
    always_ff @(posedge CLK) begin
        if (!RESET && beat) begin
            mem[wptr] <= load_data;
        end
    end

    // Word index wraps; byte offset and high PC bits are dropped.
    assign ridx  = fetch_addr[ADDR_WIDTH+1:2];
    assign hit   = run && ({1'b0, ridx} < word_count);
    assign instr = hit ? mem[ridx] : '0;

    assign unused_addr = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for the program loader, with a
// 1024-word instance and a 4-word instance sharing one stimulus.
module tb_imem_loader;

    logic        CLK;
    logic        RESET;
    logic        start_load;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic [31:0] fetch_addr;

    logic        ready_a, run_a, err_a;
    logic [31:0] instr_a;
    logic [10:0] wc_a;
    logic        ready_b, run_b, err_b;
    logic [31:0] instr_b;
    logic [2:0]  wc_b;

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } fvec_t;

    fvec_t       tbl [8];
    logic [31:0] prog [4];

    imem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut_a (
        .CLK(CLK), .RESET(RESET), .start_load(start_load),
        .load_valid(load_valid), .load_ready(ready_a),
        .load_data(load_data), .load_last(load_last),
        .run(run_a), .fetch_addr(fetch_addr), .instr(instr_a),
        .word_count(wc_a), .error(err_a)
    );

    imem_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut_b (
        .CLK(CLK), .RESET(RESET), .start_load(start_load),
        .load_valid(load_valid), .load_ready(ready_b),
        .load_data(load_data), .load_last(load_last),
        .run(run_b), .fetch_addr(fetch_addr), .instr(instr_b),
        .word_count(wc_b), .error(err_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic with_valid);
        start_load = 1'b1;
        load_valid = with_valid;
        load_data  = 32'hdeadbeef;
        load_last  = 1'b1;
        tick();
        start_load = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last,
                        input int gap);
        for (int g = 0; g < gap; g++) begin
            load_valid = 1'b0;
            tick();
            fetch_addr = 32'h0;
            #1;
            check("gap_run", {31'b0, run_a}, 32'h0);
            check("gap_instr", instr_a, 32'h0);
        end
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            fetch_addr = tbl[i].addr;
            #1;
            check({tag, "_a"}, instr_a, tbl[i].exp_a);
            check({tag, "_b"}, instr_b, tbl[i].exp_b);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        prog[0] = 32'h00004820;
        prog[1] = 32'h20090002;
        prog[2] = 32'hac090000;
        prog[3] = 32'h20090002;
        tbl[0] = '{32'h0000_0000, 32'h00004820, 32'h00004820};
        tbl[1] = '{32'h0000_0004, 32'h20090002, 32'h20090002};
        tbl[2] = '{32'h0000_0008, 32'hac090000, 32'hac090000};
        tbl[3] = '{32'h0000_0009, 32'hac090000, 32'hac090000};
        tbl[4] = '{32'h0000_000c, 32'h20090002, 32'h20090002};
        tbl[5] = '{32'h0000_0010, 32'h00000000, 32'h00004820};
        tbl[6] = '{32'h0000_0014, 32'h00000000, 32'h20090002};
        tbl[7] = '{32'h0000_1000, 32'h00004820, 32'h00004820};

        RESET      = 1'b1;
        start_load = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        fetch_addr = 32'h0;
        tick();
        tick();
        RESET = 1'b0;
        check("rst_run", {31'b0, run_a}, 32'h0);
        check("rst_ready", {31'b0, ready_a}, 32'h0);
        check("rst_wc", {21'b0, wc_a}, 32'h0);
        check("rst_err_b", {31'b0, err_b}, 32'h0);
        check("rst_instr", instr_a, 32'h0);

        // Basic load, valid held high; also an exact fill of dut_b.
        pulse_start(1'b0);
        check("ld_ready", {31'b0, ready_a}, 32'h1);
        check("ld_run", {31'b0, run_a}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("pre_last_run", {31'b0, run_a}, 32'h0);
            send(prog[i], i == 3, 0);
        end
        check("bas_run_a", {31'b0, run_a}, 32'h1);
        check("bas_wc_a", {21'b0, wc_a}, 32'd4);
        check("bas_ready_a", {31'b0, ready_a}, 32'h0);
        check("fill_run_b", {31'b0, run_b}, 32'h1);
        check("fill_wc_b", {29'b0, wc_b}, 32'd4);
        check("fill_err_b", {31'b0, err_b}, 32'h0);
        run_table("basic");

        // Same program with three idle cycles before each word.
        pulse_start(1'b0);
        check("bp_run_drop", {31'b0, run_a}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            send(prog[i], i == 3, 3);
            if (i < 3) check("bp_early_run", {31'b0, run_a}, 32'h0);
        end
        check("bp_run", {31'b0, run_a}, 32'h1);
        run_table("gaps");

        // Reload a single word from RUN.
        pulse_start(1'b0);
        check("rl_run", {31'b0, run_a}, 32'h0);
        check("rl_instr", instr_a, 32'h0);
        send(32'h8c0a0000, 1'b1, 0);
        check("rl_wc", {21'b0, wc_a}, 32'd1);
        fetch_addr = 32'h0;
        #1;
        check("rl_f0", instr_a, 32'h8c0a0000);
        fetch_addr = 32'h4;
        #1;
        check("rl_f4", instr_a, 32'h0);

        // Overflow dut_b: four words, no last.
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ov_pre_err", {31'b0, err_b}, 32'h0);
            send(prog[i], 1'b0, 0);
        end
        check("ov_err", {31'b0, err_b}, 32'h1);
        check("ov_run", {31'b0, run_b}, 32'h0);
        check("ov_ready", {31'b0, ready_b}, 32'h0);
        check("ov_a_wc", {21'b0, wc_a}, 32'd4);

        // Restart with a coincident beat: beat dropped, error sticks.
        pulse_start(1'b1);
        check("rs_wc_a", {21'b0, wc_a}, 32'd0);
        check("rs_ready_a", {31'b0, ready_a}, 32'h1);
        check("ov_sticky", {31'b0, err_b}, 32'h1);
        check("ov_sticky_rdy", {31'b0, ready_b}, 32'h0);

        // Reset after two of four beats, start_load also high.
        send(prog[0], 1'b0, 0);
        send(prog[1], 1'b0, 0);
        check("mid_wc", {21'b0, wc_a}, 32'd2);
        RESET      = 1'b1;
        start_load = 1'b1;
        tick();
        RESET      = 1'b0;
        start_load = 1'b0;
        check("mr_run", {31'b0, run_a}, 32'h0);
        check("mr_ready", {31'b0, ready_a}, 32'h0);
        check("mr_wc", {21'b0, wc_a}, 32'd0);
        check("mr_err_b", {31'b0, err_b}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 32'(i * 4);
            #1;
            check("mr_instr", instr_a, 32'h0);
        end
        tick();
        check("mr_idle_rdy", {31'b0, ready_a}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
